size_store_rmw: RTL and testbench

//  Store-side counterpart of the load size extractor: writes word, halfword or byte stores into

---
 rtl/size_store_rmw_if.sv | 24 ++
 rtl/size_store_rmw.sv | 93 +++++++++
 tb/tb_size_store_rmw.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/size_store_rmw_if.sv
// Store request / data-memory bundle for the size-aware store unit.
// The slave side is the store unit; the master side is control plus memory.
interface size_store_rmw_if;
   logic        start;
   logic [1:0]  SSizeCtrl;
   logic [31:0] addr;
   logic [31:0] data_in_B;
   logic [31:0] mem_rd_data;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wr_data;
   logic        busy;
   logic        done;

   modport master (
      output start, SSizeCtrl, addr, data_in_B, mem_rd_data,
      input  mem_addr, mem_wr, mem_wr_data, busy, done
   );

   modport slave (
      input  start, SSizeCtrl, addr, data_in_B, mem_rd_data,
      output mem_addr, mem_wr, mem_wr_data, busy, done
   );
endinterface

// File: rtl/size_store_rmw.sv
// Word/halfword/byte store unit: words written directly,
// sub-word stores read-modify-write the old word.
module size_store_rmw #(
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   size_store_rmw_if.slave bus
);
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [3:0] LAST_RD = 4'(MEM_RD_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] merge_q, merge_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        sub_word;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         merge_q <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         merge_q <= merge_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      merge_d = merge_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               addr_d = bus.addr;
               data_d = bus.data_in_B;
               size_d = bus.SSizeCtrl;
               cnt_d  = '0;
               if (bus.SSizeCtrl == SZ_HALF ||
                   bus.SSizeCtrl == SZ_BYTE)
                  state_d = S_READ;
               else
                  state_d = S_WRITE;
            end
         end
         S_READ: begin
            // Read data is valid in the final READ cycle only.
            if (cnt_q == LAST_RD) begin
               if (size_q == SZ_HALF)
                  merge_d = {bus.mem_rd_data[31:16], data_q[15:0]};
               else
                  merge_d = {bus.mem_rd_data[31:8], data_q[7:0]};
               state_d = S_WRITE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign sub_word = (size_q == SZ_HALF) || (size_q == SZ_BYTE);

   assign bus.mem_addr    = addr_q;
   assign bus.mem_wr      = (state_q == S_WRITE);
   assign bus.mem_wr_data = sub_word ? merge_q : data_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_size_store_rmw.sv
// Bench for size_store_rmw: two instances (read latency 1 and 3)
// against a latency-accurate memory model and a mask-based reference.
module tb_size_store_rmw;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   size_store_rmw_if bus0 ();
   size_store_rmw_if bus1 ();

   size_store_rmw #(.MEM_RD_LAT(1)) u_dut_l1 (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus0.slave)
   );

   size_store_rmw #(.MEM_RD_LAT(3)) u_dut_l3 (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus1.slave)
   );

   logic [1:0]        start_s;
   logic [1:0][1:0]   size_s;
   logic [1:0][31:0]  addr_s;
   logic [1:0][31:0]  b_s;
   logic [1:0][31:0]  maddr_o;
   logic [1:0][31:0]  wdata_o;
   logic [1:0]        wr_o;
   logic [1:0]        busy_o;
   logic [1:0]        done_o;

   assign bus0.start     = start_s[0];
   assign bus0.SSizeCtrl = size_s[0];
   assign bus0.addr      = addr_s[0];
   assign bus0.data_in_B = b_s[0];
   assign bus1.start     = start_s[1];
   assign bus1.SSizeCtrl = size_s[1];
   assign bus1.addr      = addr_s[1];
   assign bus1.data_in_B = b_s[1];

   assign maddr_o[0] = bus0.mem_addr;
   assign wdata_o[0] = bus0.mem_wr_data;
   assign wr_o[0]    = bus0.mem_wr;
   assign busy_o[0]  = bus0.busy;
   assign done_o[0]  = bus0.done;
   assign maddr_o[1] = bus1.mem_addr;
   assign wdata_o[1] = bus1.mem_wr_data;
   assign wr_o[1]    = bus1.mem_wr;
   assign busy_o[1]  = bus1.busy;
   assign done_o[1]  = bus1.done;

   // Sparse memory per instance; key = {instance, address}.
   logic [31:0] mem [logic [32:0]];

   function automatic logic [31:0] mem_rd(int k, logic [31:0] a);
      logic [32:0] key;
      key = {1'(k), a};
      if (mem.exists(key))
         return mem[key];
      return 32'h0;
   endfunction

   // Read data emerges MEM_RD_LAT edges after the address is seen.
   logic [31:0] pipe0;
   logic [31:0] pipe1 [3];
   always @(posedge clk) begin
      pipe0    <= mem_rd(0, maddr_o[0]);
      pipe1[0] <= mem_rd(1, maddr_o[1]);
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
   end
   assign bus0.mem_rd_data = pipe0;
   assign bus1.mem_rd_data = pipe1[2];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(logic [1:0] sz,
                                           logic [31:0] old,
                                           logic [31:0] b);
      case (sz)
         2'b01:   return (old & 32'hFFFF_0000) | (b & 32'h0000_FFFF);
         2'b10:   return (old & 32'hFFFF_FF00) | (b & 32'h0000_00FF);
         default: return b;
      endcase
   endfunction

   function automatic int ref_wr_cycle(int lat, logic [1:0] sz);
      if (sz == 2'b01 || sz == 2'b10)
         return lat + 2;
      return 1;
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge
   // of the cycle after DONE, so chained calls test back-to-back accept.
   task automatic run_store(int k, string nm, logic [1:0] sz,
                            logic [31:0] a, logic [31:0] b,
                            logic [31:0] old, bit noisy);
      int lat;
      int exp_wr;
      int exp_done;
      int wr_cnt;
      int wr_cyc;
      int dn_cnt;
      int dn_cyc;
      int busy_bad;
      logic [31:0] wr_data;
      logic [31:0] wr_addr;
      logic [31:0] exp_data;
      lat      = (k == 0) ? 1 : 3;
      exp_wr   = ref_wr_cycle(lat, sz);
      exp_done = exp_wr + 1;
      exp_data = ref_word(sz, old, b);
      wr_cnt   = 0;
      wr_cyc   = -1;
      dn_cnt   = 0;
      dn_cyc   = -1;
      busy_bad = 0;
      wr_data  = '0;
      wr_addr  = '0;
      mem[{1'(k), a}] = old;
      addr_s[k]  = a;
      b_s[k]     = b;
      size_s[k]  = sz;
      start_s[k] = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= exp_done + 1; c++) begin
         @(negedge clk);
         start_s[k] = noisy && (c == 2 || c == exp_done);
         addr_s[k]  = $urandom;
         b_s[k]     = $urandom;
         size_s[k]  = 2'($urandom);
         if (wr_o[k]) begin
            wr_cnt++;
            wr_cyc  = c;
            wr_data = wdata_o[k];
            wr_addr = maddr_o[k];
            mem[{1'(k), maddr_o[k]}] = wdata_o[k];
         end
         if (done_o[k]) begin
            dn_cnt++;
            dn_cyc = c;
         end
         if (busy_o[k] !== (c <= exp_done))
            busy_bad++;
      end
      start_s[k] = 1'b0;
      chk({nm, " wr_count"}, wr_cnt, 1);
      chk({nm, " wr_cycle"}, wr_cyc, exp_wr);
      chk({nm, " wr_data"}, wr_data, exp_data);
      chk({nm, " wr_addr"}, wr_addr, a);
      chk({nm, " done_count"}, dn_cnt, 1);
      chk({nm, " done_cycle"}, dn_cyc, exp_done);
      chk({nm, " busy_bad_cycles"}, busy_bad, 0);
   endtask

   task automatic reset_mid_read();
      int bad;
      bad = 0;
      mem[{1'b1, 32'h0000_0200}] = 32'hCAFE_F00D;
      addr_s[1]  = 32'h0000_0200;
      b_s[1]     = 32'h0000_0077;
      size_s[1]  = 2'b10;
      start_s[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[1] = 1'b0;
      @(negedge clk);
      chk("rst busy_in_read", busy_o[1], 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst busy", busy_o[1], 0);
      chk("rst mem_wr", wr_o[1], 0);
      chk("rst done", done_o[1], 0);
      chk("rst mem_addr", maddr_o[1], 0);
      chk("rst mem_wr_data", wdata_o[1], 0);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (wr_o[1] !== 1'b0 || done_o[1] !== 1'b0 ||
             busy_o[1] !== 1'b0)
            bad++;
      end
      chk("rst no_activity_after", bad, 0);
      chk("rst mem_unchanged", mem_rd(1, 32'h0000_0200), 32'hCAFE_F00D);
   endtask

   initial begin
      start_s = '0;
      size_s  = '0;
      addr_s  = '0;
      b_s     = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset%0d busy", k), busy_o[k], 0);
         chk($sformatf("reset%0d done", k), done_o[k], 0);
         chk($sformatf("reset%0d mem_wr", k), wr_o[k], 0);
         chk($sformatf("reset%0d mem_addr", k), maddr_o[k], 0);
         chk($sformatf("reset%0d wr_data", k), wdata_o[k], 0);
      end
      reset_n = 1'b1;
      @(negedge clk);

      run_store(0, "t1_word", 2'b00, 32'h40, 32'hDEAD_BEEF, 32'h5555_AAAA, 0);
      run_store(0, "t2_half", 2'b01, 32'h80, 32'hAAAA_5566, 32'h1122_3344, 0);
      run_store(1, "t3_byte", 2'b10, 32'hC0, 32'hFFFF_FF99, 32'h1122_3344, 0);
      run_store(0, "t4_ss11", 2'b11, 32'h100, 32'h1234_5678, 32'h0BAD_0BAD, 0);
      run_store(1, "t4b_word", 2'b00, 32'h104, 32'h0F0F_F0F0, 32'h3C3C_3C3C, 0);
      run_store(0, "t5_noisy0", 2'b10, 32'h140, 32'h0000_00AB, 32'h8765_4321, 1);
      run_store(0, "t5_next0", 2'b00, 32'h144, 32'h1357_9BDF, 32'h0, 0);
      run_store(1, "t5_noisy1", 2'b01, 32'h180, 32'hFFFF_1234, 32'hA5A5_5A5A, 1);
      run_store(1, "t5_next1", 2'b00, 32'h184, 32'h2468_ACE0, 32'h0, 0);
      reset_mid_read();
      run_store(1, "t6_after", 2'b00, 32'h240, 32'h7777_8888, 32'h0, 0);

      for (int i = 0; i < 24; i++) begin
         int          k;
         logic [1:0]  sz;
         logic [31:0] a;
         k  = int'($urandom_range(0, 1));
         sz = 2'($urandom);
         a  = 32'h1000 + 32'(i * 4);
         run_store(k, $sformatf("rnd%0d", i), sz, a, $urandom,
                   $urandom, bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
